// File: rtl/pile_driver.sv
// pile_driver: steps an external stack counter toward a requested height by
// issuing plus/moins press pulses. Each press is followed by a release gap.
// Direction is re-evaluated before every press, so height changes that this
// block did not cause are absorbed. A per-request step limit and an abort
// input both end the request with an error pulse.
module pile_driver #(
    parameter int PRESS_CYC = 2,
    parameter int GAP_CYC   = 2,
    parameter int MAX_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_target,
    output logic       req_ready,
    input  logic       abort,
    input  logic [2:0] hauteur,
    output logic       plus,
    output logic       moins,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_PRESS,
        S_RELEASE,
        S_FINISH
    } state_t;

    // Terminal values of the phase counter and the step limit, in counter width.
    localparam logic [3:0] PRESS_LAST = 4'(PRESS_CYC - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);
    localparam logic [3:0] STEP_LIMIT = 4'(MAX_STEPS);

    state_t     state_q, state_d;
    logic [2:0] target_q, target_d;
    logic [3:0] step_q, step_d;      // presses issued for the current request
    logic [3:0] cnt_q, cnt_d;        // cycles spent in PRESS or RELEASE
    logic       up_q, up_d;          // direction latched at the last COMPARE
    logic       abort_q, abort_d;    // abort seen; finish with error after the gap
    logic       plus_q, plus_d;
    logic       moins_q, moins_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    // Next-state and next-output logic; press lines and pulses are computed
    // from the state being entered so they appear registered with it.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        up_d     = up_q;
        abort_d  = abort_q;
        plus_d   = 1'b0;
        moins_d  = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    target_d = req_target;
                    step_d   = 4'd0;
                    abort_d  = 1'b0;
                    state_d  = S_COMPARE;
                end
            end

            S_COMPARE: begin
                if (abort) begin
                    // Abort still goes through a full gap before finishing.
                    abort_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RELEASE;
                end else if (hauteur == target_q) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (step_q == STEP_LIMIT) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    up_d    = (target_q > hauteur);
                    step_d  = (step_q == 4'hF) ? step_q : step_q + 4'd1;
                    cnt_d   = 4'd0;
                    plus_d  = up_d;
                    moins_d = !up_d;
                    state_d = S_PRESS;
                end
            end

            S_PRESS: begin
                if (abort) begin
                    // Drop the press line immediately, then take the gap.
                    abort_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RELEASE;
                end else if (cnt_q == PRESS_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    plus_d  = up_q;
                    moins_d = !up_q;
                end
            end

            S_RELEASE: begin
                abort_d = abort_q | abort;
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 4'd0;
                    if (abort_d) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_COMPARE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            target_q <= 3'd0;
            step_q   <= 4'd0;
            cnt_q    <= 4'd0;
            up_q     <= 1'b0;
            abort_q  <= 1'b0;
            plus_q   <= 1'b0;
            moins_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            up_q     <= up_d;
            abort_q  <= abort_d;
            plus_q   <= plus_d;
            moins_q  <= moins_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Handshake status follows reset directly so it is correct while reset is held.
    assign busy      = (state_q != S_IDLE) && !reset;
    assign req_ready = (state_q == S_IDLE) || reset;

    assign plus  = plus_q;
    assign moins = moins_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_pile_driver.sv
// Bench for pile_driver: an emulated stack counter feeds hauteur back, and a
// step-level reference model predicts the press pulses, the finish cycle, the
// outcome and the final height of each request.
module tb_pile_driver;

    localparam int P    = 2;
    localparam int G    = 2;
    localparam int MAXS = 8;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_target;
    logic       req_ready;
    logic       abort;
    logic [2:0] hauteur;
    logic       plus;
    logic       moins;
    logic       busy;
    logic       done;
    logic       error;

    pile_driver #(.PRESS_CYC(P), .GAP_CYC(G), .MAX_STEPS(MAXS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_ready  (req_ready),
        .abort      (abort),
        .hauteur    (hauteur),
        .plus       (plus),
        .moins      (moins),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Emulated stack counter.
    bit track_on   = 1'b1;
    int h          = 0;
    bit plus_prev  = 1'b0;
    bit moins_prev = 1'b0;

    // Reference model results, indexed by cycle offset after the accept edge
    // (offset 1 is the first COMPARE cycle).
    logic exp_plus  [0:127];
    logic exp_moins [0:127];
    int   exp_fin;
    bit   exp_done;
    int   exp_abort_off;
    int   exp_force_off;
    int   exp_h;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: the stack counter reacts to rising press lines seen at the
    // edge, then outputs are observed 1 time unit later.
    task automatic tick();
        logic p;
        logic m;
        p = plus;
        m = moins;
        @(posedge clk);
        if (track_on) begin
            if (p && !plus_prev && h < 7) h++;
            if (m && !moins_prev && h > 0) h--;
        end
        plus_prev  = p;
        moins_prev = m;
        #1;
        hauteur = 3'(h);
    endtask

    // Step-level model. ab_k: step whose phase is aborted (0 = none);
    // ab_j: -1 = its COMPARE, 0..P-1 = press cycle, P..P+G-1 = gap cycle.
    // f_k: step after whose press the height is forced to f_v (0 = none).
    task automatic build_model(input int h0, input int tgt, input bit trk,
                               input int ab_k, input int ab_j,
                               input int f_k, input int f_v);
        int mh;
        int t;
        int steps;
        int w;
        bit up;
        for (int i = 0; i < 128; i++) begin
            exp_plus[i]  = 1'b0;
            exp_moins[i] = 1'b0;
        end
        mh = h0;
        t = 1;
        steps = 0;
        exp_abort_off = 0;
        exp_force_off = 0;
        exp_fin = 0;
        exp_done = 1'b0;
        for (int guard = 0; guard < 20; guard++) begin
            if (ab_k == steps + 1 && ab_j < 0) begin
                exp_abort_off = t;
                exp_fin = t + 1 + G;
                exp_done = 1'b0;
                break;
            end
            if (mh == tgt) begin
                exp_fin = t + 1;
                exp_done = 1'b1;
                break;
            end
            if (steps == MAXS) begin
                exp_fin = t + 1;
                exp_done = 1'b0;
                break;
            end
            up = (tgt > mh);
            steps++;
            w = (ab_k == steps && ab_j < P) ? ab_j + 1 : P;
            for (int i = 0; i < w; i++) begin
                exp_plus[t + 1 + i]  = up;
                exp_moins[t + 1 + i] = !up;
            end
            if (trk) mh = up ? mh + 1 : mh - 1;
            if (ab_k == steps) begin
                exp_abort_off = t + 1 + ab_j;
                exp_fin = t + 1 + w + G;
                exp_done = 1'b0;
                break;
            end
            if (f_k == steps) begin
                exp_force_off = t + 1 + P;
                mh = f_v;
            end
            t += P + G + 1;
        end
        exp_h = mh;
    endtask

    // Issue one request and check every output on every cycle until idle.
    task automatic run_req(input string name, input bit lead, input int h0,
                           input int tgt, input bit trk, input int ab_k,
                           input int ab_j, input int f_k, input int f_v);
        build_model(h0, tgt, trk, ab_k, ab_j, f_k, f_v);
        track_on = trk;
        h = h0;
        hauteur = 3'(h0);
        req_valid = 1'b0;
        if (lead) begin
            abort = 1'($urandom_range(0, 1));   // ignored while idle
            tick();
            abort = 1'b0;
        end
        check_bit({name, ".ready_pre"}, req_ready, 1'b1);
        check_bit({name, ".busy_pre"}, busy, 1'b0);
        req_valid = 1'b1;
        req_target = 3'(tgt);
        tick();
        for (int k = 1; k <= exp_fin + 1; k++) begin
            check_bit($sformatf("%s.plus[%0d]", name, k), plus, exp_plus[k]);
            check_bit($sformatf("%s.moins[%0d]", name, k), moins, exp_moins[k]);
            check_bit($sformatf("%s.done[%0d]", name, k), done,
                      (k == exp_fin) && exp_done);
            check_bit($sformatf("%s.error[%0d]", name, k), error,
                      (k == exp_fin) && !exp_done);
            check_bit($sformatf("%s.busy[%0d]", name, k), busy, k <= exp_fin);
            check_bit($sformatf("%s.ready[%0d]", name, k), req_ready, k > exp_fin);
            // Requests while busy must be ignored, as must abort in FINISH.
            req_valid  = (k < exp_fin);
            req_target = 3'($urandom_range(0, 7));
            abort = (k == exp_abort_off) ||
                    (k == exp_fin && $urandom_range(0, 1) == 1);
            if (k == exp_force_off) begin
                h = f_v;
                hauteur = 3'(f_v);
            end
            tick();
        end
        abort = 1'b0;
        req_valid = 1'b0;
        check_int({name, ".hauteur_end"}, h, exp_h);
        $display("req %s: h0=%0d target=%0d track=%0b -> %s at offset %0d, hauteur=%0d",
                 name, h0, tgt, trk, exp_done ? "done" : "error", exp_fin, h);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_target = 3'd0;
        abort = 1'b0;
        hauteur = 3'd0;
        #1;
        tick();
        tick();
        check_bit("rst.busy", busy, 1'b0);
        check_bit("rst.ready", req_ready, 1'b1);
        check_bit("rst.plus", plus, 1'b0);
        check_bit("rst.moins", moins, 1'b0);
        check_bit("rst.done", done, 1'b0);
        check_bit("rst.error", error, 1'b0);
        // Reset wins over req_valid and abort.
        req_valid = 1'b1;
        abort = 1'b1;
        req_target = 3'd5;
        tick();
        check_bit("rst.prio_busy", busy, 1'b0);
        reset = 1'b0;
        req_valid = 1'b0;
        abort = 1'b0;
        tick();
        check_bit("rst.after_busy", busy, 1'b0);
        $display("reset: busy=%0b ready=%0b", busy, req_ready);

        // Directed requests.
        run_req("up2to5",    1'b1, 2, 5, 1'b1, 0, 0, 0, 0);
        run_req("equal4",    1'b1, 4, 4, 1'b1, 0, 0, 0, 0);
        run_req("stuck6to1", 1'b1, 6, 1, 1'b0, 0, 0, 0, 0);
        run_req("abort3to0", 1'b1, 3, 0, 1'b1, 2, 0, 0, 0);
        run_req("gravity",   1'b1, 3, 5, 1'b1, 0, 0, 1, 6);
        run_req("abortcmp",  1'b1, 1, 6, 1'b1, 2, -1, 0, 0);
        run_req("abortgap",  1'b1, 6, 2, 1'b1, 1, P + 1, 0, 0);
        run_req("top7",      1'b1, 5, 7, 1'b1, 0, 0, 0, 0);
        run_req("bottom0",   1'b1, 2, 0, 1'b1, 0, 0, 0, 0);

        // Reset during the plus high phase of a 2 -> 5 request.
        track_on = 1'b1;
        h = 2;
        hauteur = 3'd2;
        tick();
        req_valid = 1'b1;
        req_target = 3'd5;
        tick();
        req_valid = 1'b0;
        tick();
        check_bit("midrst.plus_before", plus, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("midrst.ready_in_reset", req_ready, 1'b1);
        check_bit("midrst.busy_in_reset", busy, 1'b0);
        tick();
        check_bit("midrst.plus", plus, 1'b0);
        check_bit("midrst.moins", moins, 1'b0);
        check_bit("midrst.done", done, 1'b0);
        check_bit("midrst.error", error, 1'b0);
        check_bit("midrst.ready", req_ready, 1'b1);
        check_int("midrst.hauteur", h, 3);
        $display("midreset: plus=%0b ready=%0b hauteur=%0d", plus, req_ready, h);
        reset = 1'b0;
        run_req("after_rst", 1'b0, 3, 1, 1'b1, 0, 0, 0, 0);

        // Randomized requests.
        for (int r = 0; r < 40; r++) begin
            int rh;
            int rt;
            bit rtrk;
            int rk;
            int rj;
            rh   = int'($urandom_range(0, 7));
            rt   = int'($urandom_range(0, 7));
            rtrk = ($urandom_range(0, 3) != 0);
            rk   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            rj   = int'($urandom_range(0, P + G)) - 1;
            run_req($sformatf("rnd%0d", r), 1'b1, rh, rt, rtrk, rk, rj, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
